prewish_mask_arbiter: RTL and testbench

Shares the blinky's single mask-load port (strobe + 8-bit mask) between two requesters, A and B, e.g. button pattern source and host loader. Sequences loads so the blinker always has a fixed settle window between masks. Issues a default mask once after reset, configuring the blinker before any requester is served. Sits between the requesters and the blinker's STB_I/DAT_I, clocked from the controller's system clock.

---
 rtl/prewish_mask_arbiter.sv | 121 ++++++++++++
 tb/tb_prewish_mask_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prewish_mask_arbiter.sv
// prewish_mask_arbiter: shares the blinker's mask-load port between requesters A and B,
// issues DEFAULT_MASK after reset and enforces a 2**HOLDOFF_BITS settle window after every load.
`default_nettype none

module prewish_mask_arbiter #(
  parameter int         HOLDOFF_BITS = 9,
  parameter logic [7:0] DEFAULT_MASK = 8'b10101000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       A_STB_I,
  input  logic [7:0] A_DAT_I,
  output logic       A_ACK_O,
  input  logic       B_STB_I,
  input  logic [7:0] B_DAT_I,
  output logic       B_ACK_O,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       BUSY_O
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_GRANT = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [HOLDOFF_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]              dat_q, dat_d;
  logic                    a_ack_q, a_ack_d;
  logic                    b_ack_q, b_ack_d;
  logic                    a_arm_q, a_arm_d;
  logic                    b_arm_q, b_arm_d;
  logic                    last_b_q, last_b_d;
  logic                    a_elig, b_elig, grant_a, grant_b;

  // A requester only competes once it has been seen low since its last grant.
  assign a_elig  = A_STB_I & a_arm_q;
  assign b_elig  = B_STB_I & b_arm_q;
  assign grant_a = a_elig & (~b_elig | last_b_q);
  assign grant_b = b_elig & (~a_elig | ~last_b_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    a_arm_d  = a_arm_q;
    b_arm_d  = b_arm_q;
    last_b_d = last_b_q;
    case (state_q)
      S_INIT: begin
        state_d = S_GRANT;
        dat_d   = DEFAULT_MASK;
      end
      S_IDLE: begin
        if (grant_a) begin
          state_d  = S_GRANT;
          dat_d    = A_DAT_I;
          a_ack_d  = 1'b1;
          a_arm_d  = 1'b0;
          last_b_d = 1'b0;
        end else if (grant_b) begin
          state_d  = S_GRANT;
          dat_d    = B_DAT_I;
          b_ack_d  = 1'b1;
          b_arm_d  = 1'b0;
          last_b_d = 1'b1;
        end
      end
      S_GRANT: begin
        state_d = S_HOLD;
        cnt_d   = '1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - HOLDOFF_BITS'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
    if (!A_STB_I) a_arm_d = 1'b1;
    if (!B_STB_I) b_arm_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      dat_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_arm_q  <= 1'b1;
      b_arm_q  <= 1'b1;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      a_arm_q  <= a_arm_d;
      b_arm_q  <= b_arm_d;
      last_b_q <= last_b_d;
    end
  end

  assign STB_O   = (state_q == S_GRANT);
  assign BUSY_O  = (state_q != S_IDLE);
  assign DAT_O   = dat_q;
  assign A_ACK_O = a_ack_q;
  assign B_ACK_O = b_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_prewish_mask_arbiter.sv
// Scoreboard bench for prewish_mask_arbiter: a cycle-count reference model predicts every
// load (mask + which ACK) and BUSY_O; a negedge monitor compares the DUT against it.
`default_nettype none

module tb_prewish_mask_arbiter;

  localparam int         HB      = 4;
  localparam int         HOLDN   = 1 << HB;
  localparam int         SPACING = HOLDN + 2;
  localparam logic [7:0] DEF     = 8'hA8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A_STB_I = 1'b0, B_STB_I = 1'b0;
  logic [7:0] A_DAT_I = 8'h00, B_DAT_I = 8'h00;
  logic       A_ACK_O, B_ACK_O, STB_O, BUSY_O;
  logic [7:0] DAT_O;

  prewish_mask_arbiter #(.HOLDOFF_BITS(HB), .DEFAULT_MASK(DEF)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .A_STB_I(A_STB_I), .A_DAT_I(A_DAT_I), .A_ACK_O(A_ACK_O),
    .B_STB_I(B_STB_I), .B_DAT_I(B_DAT_I), .B_ACK_O(B_ACK_O),
    .STB_O(STB_O), .DAT_O(DAT_O), .BUSY_O(BUSY_O)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected loads: {ack_a, ack_b, mask}
  logic [9:0] sb[$];

  // Reference model: the arbiter is free to sample requests from edge m_free on.
  bit         m_init, m_arm_a, m_arm_b, m_last_b, m_busy;
  logic [7:0] m_dat;
  int         m_edge, m_free;

  task automatic model_step();
    bit ea, eb, wa, wb;
    if (!rst_n) begin
      m_init = 1; m_arm_a = 1; m_arm_b = 1; m_last_b = 1; m_busy = 1;
      m_dat = 8'h00; m_edge = 0; m_free = 0;
      sb.delete();
      return;
    end
    m_edge++;
    wa = 0; wb = 0;
    if (m_init) begin
      m_init = 0;
      m_dat  = DEF;
      sb.push_back({2'b00, DEF});
      m_free = m_edge + SPACING;
      m_busy = 1;
    end else if (m_edge >= m_free) begin
      ea = A_STB_I && m_arm_a;
      eb = B_STB_I && m_arm_b;
      if (ea && eb) begin
        wa = m_last_b; wb = !m_last_b;
      end else begin
        wa = ea; wb = eb;
      end
      if (wa) begin
        m_dat = A_DAT_I; m_arm_a = 0; m_last_b = 0;
      end else if (wb) begin
        m_dat = B_DAT_I; m_arm_b = 0; m_last_b = 1;
      end
      if (wa || wb) begin
        sb.push_back({wa, wb, m_dat});
        m_free = m_edge + SPACING;
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_busy = (m_edge < m_free - 1);
    end
    if (!A_STB_I) m_arm_a = 1;
    if (!B_STB_I) m_arm_b = 1;
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: decoupled from stimulus, compares on every falling edge.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      chk("busy", int'(BUSY_O), int'(m_busy));
      chk("dat_held", int'(DAT_O), int'(m_dat));
      if (STB_O) begin
        if (sb.size() == 0) begin
          chk("spurious_stb", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("load_mask", int'(DAT_O), int'(e[7:0]));
          chk("load_acks", int'({A_ACK_O, B_ACK_O}), int'(e[9:8]));
        end
      end else begin
        if (sb.size() != 0) begin
          chk("missing_stb", sb.size(), 0);
          void'(sb.pop_front());
        end
        chk("ack_outside_grant", int'({A_ACK_O, B_ACK_O}), 0);
      end
    end
  end

  bit auto_drop = 0;

  // Requesters release their strobe on seeing their ACK when auto_drop is set.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (auto_drop) begin
        if (A_ACK_O) A_STB_I = 1'b0;
        if (B_ACK_O) B_STB_I = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    // Default mask after release, then idle
    step(25);

    // Single A request
    auto_drop = 1;
    A_DAT_I = 8'hCA; A_STB_I = 1'b1;
    step(25);

    // A held high for a long time: one grant only, re-arm after a low cycle
    auto_drop = 0;
    A_DAT_I = 8'h55; A_STB_I = 1'b1;
    step(811);
    A_STB_I = 1'b0;
    step(1);
    auto_drop = 1;
    A_STB_I = 1'b1;
    step(30);
    A_STB_I = 1'b0;

    // Ties from a fresh reset: A first, then alternation
    do_reset(2);
    step(20);
    for (int r = 0; r < 2; r++) begin
      A_DAT_I = 8'h11; B_DAT_I = 8'h22;
      A_STB_I = 1'b1; B_STB_I = 1'b1;
      step(2 * SPACING + 4);
    end

    // B raised during HOLD and withdrawn before IDLE
    A_DAT_I = 8'h77; A_STB_I = 1'b1;
    step(4);
    B_DAT_I = 8'h99; B_STB_I = 1'b1;
    step(5);
    B_STB_I = 1'b0;
    step(25);

    // Reset in HOLD with A pending
    A_DAT_I = 8'h3C; A_STB_I = 1'b1;
    step(4);
    A_STB_I = 1'b1;
    step(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stb", int'(STB_O), 0);
    chk("rst_dat", int'(DAT_O), 0);
    chk("rst_acks", int'({A_ACK_O, B_ACK_O}), 0);
    chk("rst_busy", int'(BUSY_O), 1);
    step(2);
    rst_n = 1'b1;
    step(SPACING + 20);
    A_STB_I = 1'b0;

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if (A_STB_I) begin
        if ($urandom_range(15) == 0) A_STB_I = 1'b0;
      end else if ($urandom_range(9) == 0) begin
        A_DAT_I = 8'($urandom); A_STB_I = 1'b1;
      end
      if (B_STB_I) begin
        if ($urandom_range(15) == 0) B_STB_I = 1'b0;
      end else if ($urandom_range(9) == 0) begin
        B_DAT_I = 8'($urandom); B_STB_I = 1'b1;
      end
      auto_drop = ($urandom_range(3) != 0);
      step(1);
    end
    A_STB_I = 1'b0; B_STB_I = 1'b0;
    step(SPACING + 5);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
